cpu_freg: RTL and testbench

Parametrised CPU flag register with per-flag write enables, per-flag sticky/transparent mode, explicit clear, and a save/restore stack for interrupt and call entry/exit. Sits between the ALU flag outputs and the control unit's branch logic. It replaces the fixed three-flag register with a fully synchronous design of configurable width and stack depth.

---
 rtl/cpu_flag_pkg.sv | 36 +++
 rtl/cpu_freg_if.sv | 29 ++
 rtl/cpu_flag_stack.sv | 109 ++++++++++
 rtl/cpu_freg.sv | 71 +++++++
 tb/tb_cpu_freg.sv | 137 +++++++++++++
 5 files changed

// File: rtl/cpu_flag_pkg.sv
// Shared definitions for the CPU flag register: flag bit positions, default
// geometry, stack operation encoding and the per-bit update rule.
package cpu_flag_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_B = 2;
  localparam int FLAG_N = 3;

  localparam int              NFLAGS_DEF      = 4;
  localparam logic [3:0]      STICKY_MASK_DEF = 4'b0101;
  localparam int              STACK_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } stack_op_e;

  // Clear beats write; a sticky bit can only be set by a write.
  function automatic logic flag_next(input logic cur, input logic in_v,
                                     input logic we, input logic clr,
                                     input logic sticky);
    logic r;
    if (clr) begin
      r = 1'b0;
    end else if (we) begin
      r = sticky ? (cur | in_v) : in_v;
    end else begin
      r = cur;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_freg_if.sv
// Bus between the ALU/control unit and the flag register; the slave modport is
// the flag register's view.
interface cpu_freg_if #(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int LW = $clog2(STACK_DEPTH + 1);

  logic [NFLAGS-1:0] i_flag_in;
  logic [NFLAGS-1:0] i_flag_we;
  logic [NFLAGS-1:0] i_flag_clr;
  logic              i_push;
  logic              i_pop;
  logic [NFLAGS-1:0] o_flags;
  logic [LW-1:0]     o_level;
  logic              o_full;
  logic              o_empty;
  logic              o_err;

  modport master (
    output i_flag_in, i_flag_we, i_flag_clr, i_push, i_pop,
    input  o_flags, o_level, o_full, o_empty, o_err
  );

  modport slave (
    input  i_flag_in, i_flag_we, i_flag_clr, i_push, i_pop,
    output o_flags, o_level, o_full, o_empty, o_err
  );
endinterface

// File: rtl/cpu_flag_stack.sv
// LIFO of saved flag words with push, pop and swap; reports its occupancy and
// a one-cycle misuse pulse for dropped pushes/pops.
module cpu_flag_stack
  import cpu_flag_pkg::*;
#(
  parameter int NFLAGS      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int LW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [NFLAGS-1:0] i_data,
  output logic [NFLAGS-1:0] o_top,
  output logic [LW-1:0]     o_level,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_pop_eff,
  output logic              o_err
);

  logic [NFLAGS-1:0] r_mem [STACK_DEPTH];
  logic [LW-1:0]     r_level;
  stack_op_e         w_op;
  logic              w_err;
  logic [NFLAGS-1:0] w_top;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (r_level == LW'(STACK_DEPTH));
  assign w_empty = (r_level == {LW{1'b0}});

  // Resolve push/pop requests against occupancy.
  always_comb begin
    w_op  = OP_NONE;
    w_err = 1'b0;
    case ({i_push, i_pop})
      2'b10: begin
        if (w_full) begin
          w_err = 1'b1;
        end else begin
          w_op = OP_PUSH;
        end
      end
      2'b01: begin
        if (w_empty) begin
          w_err = 1'b1;
        end else begin
          w_op = OP_POP;
        end
      end
      2'b11: begin
        if (w_empty) begin
          w_op  = OP_PUSH;
          w_err = 1'b1;
        end else begin
          w_op = OP_SWAP;
        end
      end
      default: begin
        w_op  = OP_NONE;
        w_err = 1'b0;
      end
    endcase
  end

  // Read mux for the entry at level-1.
  always_comb begin
    w_top = {NFLAGS{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      w_top = (r_level == LW'(i + 1)) ? r_mem[i] : w_top;
    end
  end

  // Occupancy counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= {LW{1'b0}};
    end else begin
      case (w_op)
        OP_PUSH: r_level <= r_level + LW'(1);
        OP_POP:  r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry storage; contents after reset are irrelevant, so no reset here.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if ((w_op == OP_PUSH) && (r_level == LW'(i))) begin
        r_mem[i] <= i_data;
      end else if ((w_op == OP_SWAP) && (r_level == LW'(i + 1))) begin
        r_mem[i] <= i_data;
      end else begin
        r_mem[i] <= r_mem[i];
      end
    end
  end

  assign o_top     = w_top;
  assign o_level   = r_level;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_pop_eff = (w_op == OP_POP) || (w_op == OP_SWAP);
  assign o_err     = w_err;

endmodule

// File: rtl/cpu_freg.sv
// CPU flag register: per-flag sticky/transparent update with clear, plus a
// save/restore stack and a sticky misuse error.
module cpu_freg
  import cpu_flag_pkg::*;
#(
  parameter int                NFLAGS      = NFLAGS_DEF,
  parameter logic [NFLAGS-1:0] STICKY_MASK = NFLAGS'(STICKY_MASK_DEF),
  parameter int                STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  cpu_freg_if.slave  bus
);

  localparam int LW = $clog2(STACK_DEPTH + 1);

  logic [NFLAGS-1:0] r_flags;
  logic              r_err;
  logic [NFLAGS-1:0] w_upd;
  logic [NFLAGS-1:0] w_top;
  logic [LW-1:0]     w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_pop_eff;
  logic              w_stk_err;

  cpu_flag_stack #(
    .NFLAGS      (NFLAGS),
    .STACK_DEPTH (STACK_DEPTH),
    .LW          (LW)
  ) u_stack (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (bus.i_push),
    .i_pop     (bus.i_pop),
    .i_data    (r_flags),
    .o_top     (w_top),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_pop_eff (w_pop_eff),
    .o_err     (w_stk_err)
  );

  // Per-bit ALU update.
  always_comb begin
    w_upd = {NFLAGS{1'b0}};
    for (int i = 0; i < NFLAGS; i++) begin
      w_upd[i] = flag_next(r_flags[i], bus.i_flag_in[i], bus.i_flag_we[i],
                           bus.i_flag_clr[i], STICKY_MASK[i]);
    end
  end

  // Flag state; a restore from the stack takes priority over WE/CLR.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flags <= {NFLAGS{1'b0}};
      r_err   <= 1'b0;
    end else begin
      r_flags <= w_pop_eff ? w_top : w_upd;
      r_err   <= r_err | w_stk_err;
    end
  end

  assign bus.o_flags = r_flags;
  assign bus.o_level = w_level;
  assign bus.o_full  = w_full;
  assign bus.o_empty = w_empty;
  assign bus.o_err   = r_err;

endmodule

// File: tb/tb_cpu_freg.sv
// Directed bench for cpu_freg: each step queues its hand-computed result and a
// monitor compares after every rising edge.
module tb_cpu_freg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_freg_if #(.NFLAGS(4), .STACK_DEPTH(4)) bus ();

  cpu_freg #(.NFLAGS(4), .STICKY_MASK(4'b0101), .STACK_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    string      nm;
    logic [9:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string nm, input logic r,
                      input logic [3:0] we, input logic [3:0] in_v,
                      input logic [3:0] clr, input logic push, input logic pop,
                      input logic [3:0] ef, input logic [2:0] el,
                      input logic eerr);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.i_flag_we  = we;
    bus.i_flag_in  = in_v;
    bus.i_flag_clr = clr;
    bus.i_push     = push;
    bus.i_pop      = pop;
    e.nm = nm;
    e.v  = {ef, el, (el == 3'd4), (el == 3'd0), eerr};
    exp_q.push_back(e);
  endtask

  // Monitor: compare {flags, level, full, empty, err} after each edge.
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.o_flags, bus.o_level, bus.o_full, bus.o_empty, bus.o_err};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got flags=%b level=%0d full=%b empty=%b err=%b, want flags=%b level=%0d full=%b empty=%b err=%b",
                   e.nm, act[9:6], act[5:3], act[2], act[1], act[0],
                   e.v[9:6], e.v[5:3], e.v[2], e.v[1], e.v[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.i_flag_we = 4'b0000; bus.i_flag_in = 4'b0000; bus.i_flag_clr = 4'b0000;
    bus.i_push = 1'b0; bus.i_pop = 1'b0;

    //     name          rst   we       in       clr      psh   pop   flags    lvl   err
    step("reset",       1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0);
    // sticky vs transparent, clear beats write
    step("wr_all1",     1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0);
    step("wr_all0",     1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0101, 3'd0, 1'b0);
    step("clr_beats_we",1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0100, 3'd0, 1'b0);
    step("hold",        1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, 3'd0, 1'b0);
    // nested save/restore
    step("set_0011",    1'b0, 4'b0011, 4'b0011, 4'b0100, 1'b0, 1'b0, 4'b0011, 3'd0, 1'b0);
    step("push1_upd",   1'b0, 4'b1100, 4'b1100, 4'b0011, 1'b1, 1'b0, 4'b1100, 3'd1, 1'b0);
    step("push2_upd",   1'b0, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b1111, 3'd2, 1'b0);
    step("pop_1100",    1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1100, 3'd1, 1'b0);
    step("pop_0011",    1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0011, 3'd0, 1'b0);
    step("pop_empty",   1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b1111, 3'd0, 1'b1);
    // reset mid-operation
    step("rst2",        1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0);
    step("push_1010",   1'b0, 4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0, 4'b1010, 3'd1, 1'b0);
    step("push_l2",     1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1010, 3'd2, 1'b0);
    step("rst_mid",     1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b0);
    step("pop_after_rst",1'b0,4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1);
    // overflow
    step("rst3",        1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0);
    step("ov_push1",    1'b0, 4'b1111, 4'b0001, 4'b0100, 1'b1, 1'b0, 4'b0001, 3'd1, 1'b0);
    step("ov_push2",    1'b0, 4'b1111, 4'b0010, 4'b0101, 1'b1, 1'b0, 4'b0010, 3'd2, 1'b0);
    step("ov_push3",    1'b0, 4'b1111, 4'b0100, 4'b0001, 1'b1, 1'b0, 4'b0100, 3'd3, 1'b0);
    step("ov_push4",    1'b0, 4'b1111, 4'b1000, 4'b0101, 1'b1, 1'b0, 4'b1000, 3'd4, 1'b0);
    step("ov_push5",    1'b0, 4'b1111, 4'b1001, 4'b0100, 1'b1, 1'b0, 4'b1001, 3'd4, 1'b1);
    step("ov_pop1",     1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 3'd3, 1'b1);
    step("ov_pop2",     1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 3'd2, 1'b1);
    step("ov_pop3",     1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 3'd1, 1'b1);
    step("ov_pop4",     1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b1);
    // swap
    step("rst4",        1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0);
    step("sw_set0001",  1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0001, 3'd0, 1'b0);
    step("sw_push",     1'b0, 4'b1111, 4'b1000, 4'b0101, 1'b1, 1'b0, 4'b1000, 3'd1, 1'b0);
    step("swap",        1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b0001, 3'd1, 1'b0);
    step("sw_pop_top",  1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1000, 3'd0, 1'b0);
    step("swap_empty",  1'b0, 4'b1111, 4'b0110, 4'b0000, 1'b1, 1'b1, 4'b0110, 3'd1, 1'b1);
    step("swe_pop",     1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1000, 3'd0, 1'b1);
    // pop overrides update, then back-to-back push/pop
    step("rst5",        1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0);
    step("po_set0010",  1'b0, 4'b1111, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, 3'd0, 1'b0);
    step("po_push",     1'b0, 4'b1111, 4'b0000, 4'b0101, 1'b1, 1'b0, 4'b0000, 3'd1, 1'b0);
    step("pop_over_we", 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 4'b0010, 3'd0, 1'b0);
    step("b2b_push1",   1'b0, 4'b1111, 4'b1000, 4'b0000, 1'b1, 1'b0, 4'b1000, 3'd1, 1'b0);
    step("b2b_pop1",    1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 3'd0, 1'b0);
    step("b2b_push2",   1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0010, 3'd1, 1'b0);
    step("b2b_pop2",    1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0010, 3'd0, 1'b0);

    @(negedge clk);
    bus.i_flag_we = 4'b0000; bus.i_flag_clr = 4'b0000;
    bus.i_push = 1'b0; bus.i_pop = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
